// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed 32x32 multiply / divide unit with HI/LO
// result registers. The operation takes 32 single-bit iterations on operand
// magnitudes; signs are applied when the result is written to HI/LO.
// Handshake: a request (multordiv or hlwrite) is accepted only at a rising
// edge where busy=0. While busy=1, requests and HI/LO reads are refused and
// stall=1 tells the upstream stage to hold and reissue the same request.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        multordiv,
  input  logic        isdiv,
  input  logic        hlwrite,
  input  logic [1:0]  mvhl,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic [31:0] hlout,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;
  logic        isdiv_q;
  logic [31:0] hi, lo;
  logic [31:0] acc_hi, acc_lo;

  logic        accept;
  logic        start;
  logic        hl_wr;
  logic        last_iter;
  logic [31:0] a_mag, b_mag, srca_mag, srcb_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [31:0] iter_hi, iter_lo;
  logic [63:0] prod_mag, prod_res;
  logic [31:0] res_hi, res_lo;

  assign accept    = (state == ST_IDLE) || (state == ST_DONE);
  assign start     = accept && multordiv;
  assign hl_wr     = accept && !multordiv && hlwrite;
  assign last_iter = (state == ST_CALC) && (cnt == 5'd0);

  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);
  assign stall     = busy && (multordiv || hlwrite || mvhl == 2'b01 || mvhl == 2'b10);
  assign dbg_state = state;

  assign srca_mag = srca[31] ? -srca : srca;
  assign srcb_mag = srcb[31] ? -srcb : srcb;
  assign a_mag    = a_q[31] ? -a_q : a_q;
  assign b_mag    = b_q[31] ? -b_q : b_q;

  // HI/LO read mux; during CALC this still shows the pre-operation values
  always_comb begin
    hlout = 32'd0;
    if (mvhl == 2'b01) hlout = lo;
    else if (mvhl == 2'b10) hlout = hi;
  end

  // One iteration: shift-add multiply step or restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
    if (isdiv_q) begin
      iter_hi = div_diff[33] ? div_shift[31:0] : div_diff[31:0];
      iter_lo = {acc_lo[30:0], ~div_diff[33]};
    end else begin
      iter_hi = mul_sum[32:1];
      iter_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // Sign fix-up of the final iteration's magnitudes, plus the divide corner cases
  always_comb begin
    prod_mag = {iter_hi, iter_lo};
    prod_res = (a_q[31] ^ b_q[31]) ? -prod_mag : prod_mag;
    if (!isdiv_q) begin
      res_hi = prod_res[63:32];
      res_lo = prod_res[31:0];
    end else if (b_q == 32'd0) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = a_q[31] ? -iter_hi : iter_hi;
      res_lo = (a_q[31] ^ b_q[31]) ? -iter_lo : iter_lo;
    end
  end

  // FSM and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        ST_CALC: begin
          if (cnt == 5'd0) state <= ST_DONE;
          else cnt <= cnt - 5'd1;
        end
        default: begin
          if (start) begin
            state <= ST_CALC;
            cnt   <= 5'd31;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Latched operands and working accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      isdiv_q <= 1'b0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
    end else if (start) begin
      a_q     <= srca;
      b_q     <= srcb;
      isdiv_q <= isdiv;
      acc_hi  <= 32'd0;
      acc_lo  <= isdiv ? srca_mag : srcb_mag;
    end else if (state == ST_CALC) begin
      acc_hi  <= iter_hi;
      acc_lo  <= iter_lo;
    end
  end

  // HI/LO: committed after the last iteration, or written directly when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (last_iter) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (hl_wr) begin
      if (mvhl == 2'b10) hi <= srca;
      else if (mvhl == 2'b01) lo <= srca;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors plus randomized operations
// checked against a signed-arithmetic reference model and an expected queue.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        multordiv;
  logic        isdiv;
  logic        hlwrite;
  logic [1:0]  mvhl;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] hlout;
  logic        busy;
  logic        done;
  logic        stall;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .multordiv (multordiv),
    .isdiv     (isdiv),
    .hlwrite   (hlwrite),
    .mvhl      (mvhl),
    .srca      (srca),
    .srcb      (srcb),
    .hlout     (hlout),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: {HI, LO} from plain signed arithmetic
  function automatic logic [63:0] ref_result(input logic d, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    multordiv = 1'b0;
    hlwrite   = 1'b0;
    mvhl      = 2'b00;
  endtask

  // issue one request at the next edge; exp is the required {HI, LO}
  task automatic start_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic with_hlw, input logic [63:0] exp);
    multordiv = 1'b1;
    isdiv     = d;
    srca      = a;
    srcb      = b;
    hlwrite   = with_hlw;
    mvhl      = with_hlw ? 2'b10 : 2'b00;
    exp_q.push_back(exp);
    tick();
    idle_inputs();
    srca = $urandom;
    srcb = $urandom;
  endtask

  // follow an operation from its first CALC cycle to the DONE cycle
  task automatic wait_result(input string name, input logic poke, input logic chain);
    logic [63:0] exp;
    for (int i = 1; i <= 32; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/done cyc %0d: got %b/%b want 1/0", name, i, busy, done);
      end
      if (i == 5) begin
        mvhl = 2'b01; #1;
        n_checks++;
        if (hlout !== model_lo || stall !== 1'b1) begin
          n_fail++;
          $display("FAIL %s pre-op LO: got %h stall %b want %h stall 1", name, hlout, stall, model_lo);
        end
        mvhl = 2'b10; #1;
        n_checks++;
        if (hlout !== model_hi) begin
          n_fail++;
          $display("FAIL %s pre-op HI: got %h want %h", name, hlout, model_hi);
        end
        mvhl = 2'b00; #1;
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stall idle-in: got %b want 0", name, stall);
        end
      end
      if (poke && i == 3) begin
        multordiv = 1'b1;
        hlwrite   = 1'b1;
        mvhl      = 2'b10;
        isdiv     = ~isdiv;
        srca      = $urandom;
        srcb      = $urandom;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall on busy request: got %b want 1", name, stall);
        end
      end
      if (i < 32) begin
        tick();
        idle_inputs();
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done/busy at cycle 33: got %b/%b want 1/0", name, done, busy);
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard empty: got 0 entries want 1", name);
    end else begin
      exp = exp_q.pop_front();
      mvhl = 2'b10; #1;
      n_checks++;
      if (hlout !== exp[63:32]) begin
        n_fail++;
        $display("FAIL %s HI: got %h want %h", name, hlout, exp[63:32]);
      end
      mvhl = 2'b01; #1;
      n_checks++;
      if (hlout !== exp[31:0]) begin
        n_fail++;
        $display("FAIL %s LO: got %h want %h", name, hlout, exp[31:0]);
      end
      mvhl = 2'b00;
      model_hi = exp[63:32];
      model_lo = exp[31:0];
    end
    if (!chain) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after done: got done %b busy %b want 0/0", name, done, busy);
      end
    end
  endtask

  task automatic check_hl(input string name);
    mvhl = 2'b10; #1;
    n_checks++;
    if (hlout !== model_hi) begin
      n_fail++;
      $display("FAIL %s HI: got %h want %h", name, hlout, model_hi);
    end
    mvhl = 2'b01; #1;
    n_checks++;
    if (hlout !== model_lo) begin
      n_fail++;
      $display("FAIL %s LO: got %h want %h", name, hlout, model_lo);
    end
    mvhl = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    isdiv = 1'b0;
    srca  = 32'd0;
    srcb  = 32'd0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || hlout !== 32'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy %b done %b stall %b hlout %h want 0 0 0 0",
               busy, done, stall, hlout);
    end
    check_hl("reset");
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_directed();
    start_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    wait_result("mul 7*-3", 1'b0, 1'b0);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_result("div -7/2", 1'b0, 1'b0);
    start_op(1'b1, 32'd100, 32'd0, 1'b0, {32'd100, 32'hFFFF_FFFF});
    wait_result("div 100/0", 1'b0, 1'b0);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'h8000_0000});
    wait_result("div min/-1", 1'b0, 1'b0);
    start_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, {32'h4000_0000, 32'd0});
    wait_result("mul min*min", 1'b0, 1'b0);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    wait_result("div -7/0", 1'b0, 1'b0);
  endtask

  task automatic test_hlwrite();
    hlwrite = 1'b1; mvhl = 2'b10; srca = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    model_hi = 32'hDEAD_BEEF;
    check_hl("mthi");
    hlwrite = 1'b1; mvhl = 2'b01; srca = 32'h1234_5678;
    tick();
    idle_inputs();
    model_lo = 32'h1234_5678;
    check_hl("mtlo");
    hlwrite = 1'b1; mvhl = 2'b11; srca = 32'h5555_AAAA;
    tick();
    mvhl = 2'b00; #1;
    n_checks++;
    if (hlout !== 32'd0) begin
      n_fail++;
      $display("FAIL hlout sel00: got %h want 0", hlout);
    end
    mvhl = 2'b11; #1;
    n_checks++;
    if (hlout !== 32'd0) begin
      n_fail++;
      $display("FAIL hlout sel11: got %h want 0", hlout);
    end
    idle_inputs();
    check_hl("mvhl 11 no write");
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    start_op(1'b0, a, b, 1'b0, ref_result(1'b0, a, b));
    wait_result("busy ignore", 1'b1, 1'b0);
    // request that carries both: the hlwrite must be dropped
    hlwrite = 1'b1; mvhl = 2'b10; srca = 32'hCAFE_0001;
    tick();
    idle_inputs();
    model_hi = 32'hCAFE_0001;
    check_hl("mthi before priority");
    start_op(1'b1, 32'd1000, 32'd7, 1'b1, ref_result(1'b1, 32'd1000, 32'd7));
    wait_result("mult/hlwrite priority", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_op(1'b0, 32'd5, 32'd6, 1'b0, 64'd30);
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b0;
    #1;
    exp_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset mid-calc: got busy %b done %b stall %b want 0 0 0", busy, done, stall);
    end
    check_hl("reset mid-calc");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL aborted op resurfaced: got done %b busy %b want 0/0", done, busy);
      end
    end
    check_hl("no commit after abort");
    start_op(1'b0, 32'd3, 32'd4, 1'b0, {32'd0, 32'd12});
    wait_result("mul 3*4 after reset", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    start_op(1'b0, 32'hFFFF_0000, 32'd17, 1'b0, ref_result(1'b0, 32'hFFFF_0000, 32'd17));
    wait_result("b2b first", 1'b0, 1'b1);
    a = $urandom;
    b = $urandom_range(1, 1000);
    start_op(1'b1, a, b, 1'b0, ref_result(1'b1, a, b));
    wait_result("b2b second", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic d;
    for (int n = 0; n < 20; n++) begin
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      start_op(d, a, b, 1'b0, ref_result(d, a, b));
      wait_result(d ? "rand div" : "rand mul", 1'b0, (n % 3) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hlwrite();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
